// File: rtl/clkdiv_pkg.sv
// clkdiv_pkg: FSM states, bypass threshold and WAIT_LOW timeout length shared by the divider config sequencer
package clkdiv_pkg;
   typedef enum logic [2:0] {IDLE, WAIT_LOW, DISABLE, LOAD, ENABLE, DONE} state_t;
   localparam int BYPASS_THR = 2;
   function automatic int tmo_cyc(input int width);
      return (1 << width) + 1;
   endfunction
endpackage

// File: rtl/clkdiv_cfg_tmr.sv
// clkdiv_cfg_tmr: loadable down-counter that stops at zero, shared by the settle and timeout waits
//   clk, rst_n : clock and async active-low reset
//   load       : load load_val this cycle (takes priority over counting)
//   load_val   : value loaded; zero is seen load_val+1 edges after the load
//   zero       : counter has reached zero
module clkdiv_cfg_tmr #(
   parameter int W = 5
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         zero
);
   logic [W-1:0] cnt;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cnt <= '0;
      else if (load) cnt <= load_val;
      else if (cnt != '0) cnt <= cnt - 1'b1;
   assign zero = (cnt == '0);
endmodule

// File: rtl/clkdiv_cfg_ctrl.sv
// clkdiv_cfg_ctrl: glitch-safe ratio update sequencer driving an integer clock divider's enable and ratio
//   i_ref_clk, i_rst_n       : reference clock, async active-low reset
//   i_req_valid/i_req_ratio  : ratio update request, accepted when o_req_ready is high
//   o_req_ready              : high while idle
//   i_div_clk                : divided clock fed back from the divider
//   o_clk_en, o_div_ratio    : divider enable and ratio
//   o_busy, o_done, o_timeout: sequence status; done and timeout are one-cycle pulses
module clkdiv_cfg_ctrl import clkdiv_pkg::*; #(
   parameter int WIDTH         = 4,
   parameter int SETTLE_CYC    = 2,
   parameter int DEFAULT_RATIO = 1
) (
   input  logic             i_ref_clk,
   input  logic             i_rst_n,
   input  logic             i_req_valid,
   input  logic [WIDTH-1:0] i_req_ratio,
   output logic             o_req_ready,
   input  logic             i_div_clk,
   output logic             o_clk_en,
   output logic [WIDTH-1:0] o_div_ratio,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_timeout
);
   localparam int TMO  = tmo_cyc(WIDTH);
   localparam int TMAX = (TMO - 1 > SETTLE_CYC - 1) ? TMO - 1 : SETTLE_CYC - 1;
   localparam int TW   = $clog2(TMAX + 1);
   state_t           state;
   logic [WIDTH-1:0] pending;
   logic             target_en;
   logic             req_en;
   logic             same;
   logic             tmr_load;
   logic             tmr_zero;
   logic [TW-1:0]    tmr_val;
   assign o_req_ready = (state == IDLE);
   assign req_en      = (i_req_ratio >= WIDTH'(BYPASS_THR));
   assign same        = (i_req_ratio == o_div_ratio) && (req_en == o_clk_en);
   // load on leaving IDLE for a real change, and again when WAIT_LOW hands over to DISABLE
   assign tmr_load = (o_req_ready && i_req_valid && !same) ||
                     (state == WAIT_LOW && (!i_div_clk || tmr_zero));
   assign tmr_val  = (o_req_ready && o_clk_en) ? TW'(TMO - 1) : TW'(SETTLE_CYC - 1);
   clkdiv_cfg_tmr #(.W(TW)) u_tmr (
      .clk      (i_ref_clk),
      .rst_n    (i_rst_n),
      .load     (tmr_load),
      .load_val (tmr_val),
      .zero     (tmr_zero)
   );
   always_ff @(posedge i_ref_clk or negedge i_rst_n)
      if (!i_rst_n) begin
         state       <= IDLE;
         pending     <= WIDTH'(DEFAULT_RATIO);
         target_en   <= 1'b0;
         o_clk_en    <= 1'b0;
         o_div_ratio <= WIDTH'(DEFAULT_RATIO);
         o_busy      <= 1'b0;
         o_done      <= 1'b0;
         o_timeout   <= 1'b0;
      end else begin
         o_done    <= 1'b0;
         o_timeout <= 1'b0;
         case (state)
            IDLE:
               if (i_req_valid) begin
                  pending   <= i_req_ratio;
                  target_en <= req_en;
                  if (same) begin
                     state  <= DONE;
                     o_done <= 1'b1;
                  end else begin
                     state  <= o_clk_en ? WAIT_LOW : DISABLE;
                     o_busy <= 1'b1;
                  end
               end
            WAIT_LOW:
               if (!i_div_clk || tmr_zero) begin
                  state     <= DISABLE;
                  o_clk_en  <= 1'b0;
                  o_timeout <= i_div_clk;
               end
            DISABLE:
               if (tmr_zero) begin
                  state       <= LOAD;
                  o_div_ratio <= pending;
               end
            LOAD: begin
               state    <= ENABLE;
               o_clk_en <= target_en;
            end
            ENABLE: begin
               state  <= DONE;
               o_done <= 1'b1;
            end
            DONE: begin
               state  <= IDLE;
               o_busy <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_clkdiv_cfg_ctrl.sv
// tb_clkdiv_cfg_ctrl: randomized self-checking bench for the divider config sequencer with a behavioural divider
module tb_clkdiv_cfg_ctrl;
   localparam int W   = 4;
   localparam int S   = 2;
   localparam int TMO = 2**W + 1;
   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         req_valid = 1'b0;
   logic [W-1:0] req_ratio = '0;
   logic         req_ready, clk_en, busy, done, timeout, div_clk;
   logic [W-1:0] div_ratio;
   int           checks = 0, errors = 0, mode = 0;
   int           dcnt = 0;
   logic         dq = 1'b0;
   logic [W-1:0] m_ratio = 1;
   logic         m_en = 1'b0;
   bit           pw_chk = 0;
   int           pw_run = 0;
   logic         last_dc = 1'b0;

   always #5 clk = ~clk;

   clkdiv_cfg_ctrl #(.WIDTH(W), .SETTLE_CYC(S), .DEFAULT_RATIO(1)) dut (
      .i_ref_clk   (clk),
      .i_rst_n     (rst_n),
      .i_req_valid (req_valid),
      .i_req_ratio (req_ratio),
      .o_req_ready (req_ready),
      .i_div_clk   (div_clk),
      .o_clk_en    (clk_en),
      .o_div_ratio (div_ratio),
      .o_busy      (busy),
      .o_done      (done),
      .o_timeout   (timeout)
   );

   // divider stand-in: period = ratio, high for ratio/2 cycles, output gated by enable
   assign div_clk = (mode == 1) ? 1'b1 : (mode == 2) ? 1'b0 : (dq & clk_en);
   always @(posedge clk or negedge rst_n)
      if (!rst_n) begin dcnt <= 0; dq <= 1'b0; end
      else if (!clk_en) begin dcnt <= 0; dq <= 1'b0; end
      else begin
         dcnt <= (dcnt >= int'(div_ratio) - 1) ? 0 : dcnt + 1;
         dq   <= (dcnt < int'(div_ratio) / 2);
      end

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (div_clk === last_dc) pw_run++;
      else begin
         if (pw_chk) chk("pulse_width_ge2", int'(pw_run >= 2), 1);
         pw_run  = 1;
         last_dc = div_clk;
      end
   end

   task automatic check_outs(input string p, input logic [W-1:0] er, input logic een,
                             input logic eb, input logic ed, input logic et, input logic erdy);
      chk({p, ".ratio"}, div_ratio, er);
      chk({p, ".clk_en"}, clk_en, een);
      chk({p, ".busy"}, busy, eb);
      chk({p, ".done"}, done, ed);
      chk({p, ".timeout"}, timeout, et);
      chk({p, ".ready"}, req_ready, erdy);
   endtask

   // Timeline model: accept at edge 0; divider disabled at edge k (k=0 from bypass),
   // new ratio at d-2, enable at d-1, done pulse after edge d, idle again after edge d+1.
   task automatic run_req(input logic [W-1:0] r, input bit chain, input logic [W-1:0] nxt);
      logic [W-1:0] old_r;
      logic         old_en, tgt, noop, to;
      int           k, d;
      old_r = m_ratio;
      old_en = m_en;
      tgt = (r >= 2);
      noop = (r == old_r) && (tgt == old_en);
      chk("ready_idle", req_ready, 1);
      req_valid = 1'b1;
      req_ratio = r;
      @(posedge clk);
      to = 1'b0;
      k = (noop || !old_en) ? 0 : -1;
      d = noop ? 0 : (k == 0 ? S + 2 : 1000);
      for (int m = 0; m <= d + 1 && m < 64; m++) begin
         @(negedge clk);
         if (m == 0) begin
            req_valid = chain;
            req_ratio = chain ? nxt : W'($urandom);
         end
         check_outs("seq",
                    (!noop && m >= d - 2) ? r : old_r,
                    (noop || k < 0 || m < k) ? old_en : ((m >= d - 1) ? tgt : 1'b0),
                    !noop && m <= d, m == d, to && m == k, m > d);
         if (k < 0 && (div_clk == 1'b0 || m + 1 == TMO)) begin
            k = m + 1;
            to = div_clk;
            d = k + S + 2;
         end
      end
      m_ratio = r;
      m_en = tgt;
   endtask

   task automatic measure_period(input int exp);
      int   t0, n;
      logic prev;
      t0 = -1;
      n = 0;
      prev = div_clk;
      for (int i = 0; i < 40 && n < 2; i++) begin
         @(negedge clk);
         if (div_clk && !prev) begin
            if (n == 1) chk("period", i - t0, exp);
            t0 = i;
            n++;
         end
         prev = div_clk;
      end
      if (n < 2) chk("period_edges_seen", n, 2);
   endtask

   initial begin
      logic [W-1:0] r, nxt_r;
      bit           ch, ch_prev;
      int           p;
      repeat (2) @(negedge clk);
      check_outs("reset", 1, 0, 0, 0, 0, 1);
      rst_n = 1'b1;
      @(negedge clk);
      check_outs("reset_rel", 1, 0, 0, 0, 0, 1);
      // bypass -> 4
      run_req(4, 0, 0);
      measure_period(4);
      // 4 -> 5 requested while the divided clock is high
      for (int i = 0; i < 20 && !div_clk; i++) @(negedge clk);
      chk("div_high_before_req", div_clk, 1);
      pw_chk = 1;
      run_req(5, 0, 0);
      repeat (12) @(negedge clk);
      pw_chk = 0;
      // queued second request held valid through the first
      run_req(3, 1, 6);
      run_req(6, 0, 0);
      // bypass ratios
      run_req(0, 0, 0);
      run_req(1, 0, 0);
      // same ratio twice, second is a no-op
      run_req(6, 0, 0);
      run_req(6, 0, 0);
      // divided clock stuck high -> timeout
      mode = 1;
      run_req(7, 0, 0);
      mode = 0;
      // reset during DISABLE
      req_valid = 1'b1;
      req_ratio = 2;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      for (int i = 0; i < 40 && clk_en; i++) @(negedge clk);
      chk("disable_reached", clk_en, 0);
      chk("disable_busy", busy, 1);
      #2 rst_n = 1'b0;
      #1 check_outs("reset_mid", 1, 0, 0, 0, 0, 1);
      @(negedge clk);
      rst_n = 1'b1;
      m_ratio = 1;
      m_en = 1'b0;
      repeat (4) @(negedge clk);
      check_outs("post_reset", 1, 0, 0, 0, 0, 1);
      // randomized requests
      ch_prev = 0;
      nxt_r = '0;
      for (int i = 0; i < 40; i++) begin
         p = $urandom_range(0, 9);
         mode = (p == 0) ? 1 : (p == 1) ? 2 : 0;
         r = ch_prev ? nxt_r : (($urandom_range(0, 4) == 0) ? m_ratio : W'($urandom));
         ch = ($urandom_range(0, 3) == 0);
         nxt_r = ($urandom_range(0, 3) == 0) ? r : W'($urandom);
         run_req(r, ch, nxt_r);
         ch_prev = ch;
         if (!ch) repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      mode = 0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
      $fatal(1);
   end
endmodule
